// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: address width and FSM state encoding.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;

  typedef enum logic [2:0] {
    STATE_IDLE      = 3'd0,
    STATE_ADDR      = 3'd1,
    STATE_ADDR_ACK  = 3'd2,
    STATE_WR_DATA   = 3'd3,
    STATE_WR_ACK    = 3'd4,
    STATE_RD_DATA   = 3'd5,
    STATE_RD_ACK    = 3'd6,
    STATE_WAIT_STOP = 3'd7
  } state_t;

endpackage

// File: rtl/i2c_slave_if.sv
// User-side byte handshake between the I2C slave and its host logic.
interface i2c_slave_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rd_req;
  logic       tx_underrun;
  logic       addr_hit;
  logic       busy;

  modport slave (
    output rx_data, rx_valid, rd_req, tx_underrun, addr_hit, busy,
    input  tx_data, tx_valid
  );

  modport master (
    input  rx_data, rx_valid, rd_req, tx_underrun, addr_hit, busy,
    output tx_data, tx_valid
  );

endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer plus history flop for one bus line; flags edges.
module i2c_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // Flops reset to the idle-bus level so reset release produces no edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C slave: 7-bit address match, byte write/read with ACK handling.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  i2c_slave_if.slave bus
);

  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic start, stop;

  i2c_sync_edge #(.STAGES(STAGES)) u_scl_sync (
    .clk(clk), .reset(reset), .d(scl),
    .level(scl_s), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_sync_edge #(.STAGES(STAGES)) u_sda_sync (
    .clk(clk), .reset(reset), .d(sda),
    .level(sda_s), .rise(sda_rise), .fall(sda_fall)
  );

  assign start = sda_fall & scl_s;
  assign stop  = sda_rise & scl_s;

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n, bit_inc;
  logic [7:0] shift, shift_n, shift_in;
  logic [7:0] tx_shift, tx_shift_n, next_byte;
  logic [7:0] rx_data, rx_data_n;
  logic       sda_oe, sda_oe_n;
  logic       rx_valid, rx_valid_n, rd_req, rd_req_n;
  logic       tx_underrun, tx_underrun_n;
  logic       addr_hit, addr_hit_n, busy, busy_n;

  assign next_byte = bus.tx_valid ? bus.tx_data : 8'hFF;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= STATE_IDLE;
    else        state <= state_n;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt     <= '0;
      shift       <= '0;
      tx_shift    <= '0;
      rx_data     <= '0;
      sda_oe      <= 1'b0;
      rx_valid    <= 1'b0;
      rd_req      <= 1'b0;
      tx_underrun <= 1'b0;
      addr_hit    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      bit_cnt     <= bit_cnt_n;
      shift       <= shift_n;
      tx_shift    <= tx_shift_n;
      rx_data     <= rx_data_n;
      sda_oe      <= sda_oe_n;
      rx_valid    <= rx_valid_n;
      rd_req      <= rd_req_n;
      tx_underrun <= tx_underrun_n;
      addr_hit    <= addr_hit_n;
      busy        <= busy_n;
    end
  end

  // Next-state and next-value logic; START/STOP override every state.
  // In the ACK slots sda_oe doubles as the phase flag: the first scl_fall
  // starts the drive, the second ends the slot.
  always_comb begin
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    shift_n       = shift;
    tx_shift_n    = tx_shift;
    rx_data_n     = rx_data;
    sda_oe_n      = sda_oe;
    rx_valid_n    = 1'b0;
    rd_req_n      = 1'b0;
    tx_underrun_n = 1'b0;
    addr_hit_n    = addr_hit;
    busy_n        = busy;
    shift_in      = {shift[6:0], sda_s};
    bit_inc       = bit_cnt + 4'd1;

    if (start) begin
      state_n    = STATE_ADDR;
      bit_cnt_n  = '0;
      sda_oe_n   = 1'b0;
      busy_n     = 1'b1;
      addr_hit_n = 1'b0;
    end else if (stop) begin
      state_n    = STATE_IDLE;
      bit_cnt_n  = '0;
      sda_oe_n   = 1'b0;
      busy_n     = 1'b0;
      addr_hit_n = 1'b0;
    end else begin
      case (state)
        STATE_IDLE, STATE_WAIT_STOP: sda_oe_n = 1'b0;
        STATE_ADDR: if (scl_rise) begin
          shift_n   = shift_in;
          bit_cnt_n = bit_inc;
          if (bit_inc == 4'd8) begin
            if (shift_in[7:1] == SLAVE_ADDR) begin
              state_n    = STATE_ADDR_ACK;
              addr_hit_n = 1'b1;
            end else begin
              state_n = STATE_WAIT_STOP;
            end
          end
        end
        STATE_ADDR_ACK, STATE_WR_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe_n = 1'b1;
          end else begin
            sda_oe_n  = 1'b0;
            bit_cnt_n = '0;
            if (state == STATE_WR_ACK || !shift[0]) begin
              state_n = STATE_WR_DATA;
            end else begin
              state_n       = STATE_RD_DATA;
              rd_req_n      = 1'b1;
              tx_underrun_n = ~bus.tx_valid;
              tx_shift_n    = next_byte;
              sda_oe_n      = ~next_byte[7];
            end
          end
        end
        STATE_WR_DATA: if (scl_rise) begin
          shift_n   = shift_in;
          bit_cnt_n = bit_inc;
          if (bit_inc == 4'd8) begin
            rx_data_n  = shift_in;
            rx_valid_n = 1'b1;
            state_n    = STATE_WR_ACK;
          end
        end
        STATE_RD_DATA: if (scl_fall) begin
          bit_cnt_n = bit_inc;
          if (bit_inc == 4'd8) begin
            sda_oe_n = 1'b0;
            state_n  = STATE_RD_ACK;
          end else begin
            tx_shift_n = {tx_shift[6:0], tx_shift[7]};
            sda_oe_n   = ~tx_shift[6];
          end
        end
        STATE_RD_ACK: begin
          if (scl_rise && sda_s) begin
            state_n = STATE_WAIT_STOP;
          end else if (scl_fall) begin
            state_n       = STATE_RD_DATA;
            bit_cnt_n     = '0;
            rd_req_n      = 1'b1;
            tx_underrun_n = ~bus.tx_valid;
            tx_shift_n    = next_byte;
            sda_oe_n      = ~next_byte[7];
          end
        end
      endcase
    end
  end

  assign sda             = sda_oe ? 1'b0 : 1'bz;
  assign bus.rx_data     = rx_data;
  assign bus.rx_valid    = rx_valid;
  assign bus.rd_req      = rd_req;
  assign bus.tx_underrun = tx_underrun;
  assign bus.addr_hit    = addr_hit;
  assign bus.busy        = busy;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: bus-level master plus transaction model.
module tb_i2c_slave;

  localparam time Q = 80ns;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_if bus ();

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl(m_scl), .sda(sda), .bus(bus)
  );

  always #5ns clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rx_cnt = 0, rd_cnt = 0, un_cnt = 0, dut_low = 0, busy_drop = 0;
  logic busy_watch = 1'b0;
  logic [7:0] rx_q[$];

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      rx_q.push_back(bus.rx_data);
      rx_cnt++;
    end
    if (bus.rd_req) rd_cnt++;
    if (bus.tx_underrun) un_cnt++;
    if (sda === 1'b0 && !m_sda_low) dut_low++;
    if (busy_watch && !bus.busy) busy_drop++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic bit_x(input logic b, output logic s);
    m_sda_low = ~b; #Q;
    m_scl = 1'b1; #Q;
    s = sda; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic send_start();
    if (!m_scl) begin
      m_sda_low = 1'b0; #Q;
      m_scl = 1'b1; #Q;
    end
    m_sda_low = 1'b1; #Q;
    m_scl = 1'b0; #Q;
  endtask

  task automatic send_stop();
    m_sda_low = 1'b1; #Q;
    m_scl = 1'b1; #Q;
    m_sda_low = 1'b0; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(d[i], s);
    bit_x(1'b1, ack);
  endtask

  // Reads one byte; the next byte's tx settings are presented during the ACK slot.
  task automatic rd_byte(input logic ack, input logic nv, input logic [7:0] nd,
                         output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      d[i] = s;
    end
    bus.tx_valid = nv;
    bus.tx_data  = nd;
    bit_x(ack ? 1'b0 : 1'b1, s);
  endtask

  task automatic test_reset();
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1ns reset = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if (bus.rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data); end
    n_cmp++; if (bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
    n_cmp++; if (bus.rd_req !== 1'b0) begin n_bad++; $display("FAIL reset_rd_req: got %b expected 0", bus.rd_req); end
    n_cmp++; if (bus.tx_underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun: got %b expected 0", bus.tx_underrun); end
    n_cmp++; if (bus.addr_hit !== 1'b0) begin n_bad++; $display("FAIL reset_addr_hit: got %b expected 0", bus.addr_hit); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL reset_sda: got %b expected 1", sda); end
  endtask

  task automatic test_write_basic();
    logic a0, a1;
    int rx0;
    rx0 = rx_cnt; rx_q.delete();
    send_start();
    wr_byte(8'hA0, a0);
    n_cmp++; if (bus.addr_hit !== 1'b1) begin n_bad++; $display("FAIL wr_addr_hit: got %b expected 1", bus.addr_hit); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy: got %b expected 1", bus.busy); end
    wr_byte(8'h3C, a1);
    send_stop(); #(2*Q);
    n_cmp++; if (a0 !== 1'b0) begin n_bad++; $display("FAIL wr_addr_ack: got %b expected 0", a0); end
    n_cmp++; if (a1 !== 1'b0) begin n_bad++; $display("FAIL wr_data_ack: got %b expected 0", a1); end
    n_cmp++; if (rx_cnt - rx0 !== 1) begin n_bad++; $display("FAIL wr_rx_pulses: got %0d expected 1", rx_cnt - rx0); end
    n_cmp++; if (bus.rx_data !== 8'h3C) begin n_bad++; $display("FAIL wr_rx_data: got %h expected 3c", bus.rx_data); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_end: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.addr_hit !== 1'b0) begin n_bad++; $display("FAIL wr_hit_end: got %b expected 0", bus.addr_hit); end
  endtask

  task automatic test_read_basic();
    logic a0, s0, s1;
    logic [7:0] d;
    int rd0, un0;
    rd0 = rd_cnt; un0 = un_cnt;
    bus.tx_valid = 1'b1; bus.tx_data = 8'h96;
    send_start();
    wr_byte(8'hA1, a0);
    rd_byte(1'b0, 1'b0, 8'h00, d);
    bit_x(1'b1, s0);
    bit_x(1'b1, s1);
    n_cmp++; if (a0 !== 1'b0) begin n_bad++; $display("FAIL rd_addr_ack: got %b expected 0", a0); end
    n_cmp++; if (d !== 8'h96) begin n_bad++; $display("FAIL rd_bits: got %h expected 96", d); end
    n_cmp++; if (rd_cnt - rd0 !== 1) begin n_bad++; $display("FAIL rd_req_pulses: got %0d expected 1", rd_cnt - rd0); end
    n_cmp++; if (un_cnt - un0 !== 0) begin n_bad++; $display("FAIL rd_underrun: got %0d expected 0", un_cnt - un0); end
    n_cmp++; if ({s0, s1} !== 2'b11) begin n_bad++; $display("FAIL rd_wait_stop_release: got %b expected 11", {s0, s1}); end
    n_cmp++; if (bus.addr_hit !== 1'b1) begin n_bad++; $display("FAIL rd_hit_hold: got %b expected 1", bus.addr_hit); end
    send_stop(); #(2*Q);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_end: got %b expected 0", bus.busy); end
  endtask

  task automatic test_addr_miss();
    logic a0, a1;
    int rx0, low0;
    rx0 = rx_cnt; low0 = dut_low;
    send_start();
    wr_byte(8'hA2, a0);
    wr_byte(8'h55, a1);
    n_cmp++; if ({a0, a1} !== 2'b11) begin n_bad++; $display("FAIL miss_acks: got %b expected 11", {a0, a1}); end
    n_cmp++; if (bus.addr_hit !== 1'b0) begin n_bad++; $display("FAIL miss_hit: got %b expected 0", bus.addr_hit); end
    send_stop(); #(2*Q);
    n_cmp++; if (rx_cnt - rx0 !== 0) begin n_bad++; $display("FAIL miss_rx: got %0d expected 0", rx_cnt - rx0); end
    n_cmp++; if (dut_low - low0 !== 0) begin n_bad++; $display("FAIL miss_drive: got %0d expected 0", dut_low - low0); end
  endtask

  task automatic test_underrun();
    logic a0;
    logic [7:0] d0, d1;
    int rd0, un0;
    rd0 = rd_cnt; un0 = un_cnt;
    bus.tx_valid = 1'b0; bus.tx_data = 8'h24;
    send_start();
    wr_byte(8'hA1, a0);
    rd_byte(1'b1, 1'b0, 8'h42, d0);
    rd_byte(1'b0, 1'b0, 8'h00, d1);
    send_stop(); #(2*Q);
    n_cmp++; if ({d0, d1} !== 16'hFFFF) begin n_bad++; $display("FAIL un_bytes: got %h expected ffff", {d0, d1}); end
    n_cmp++; if (un_cnt - un0 !== 2) begin n_bad++; $display("FAIL un_pulses: got %0d expected 2", un_cnt - un0); end
    n_cmp++; if (rd_cnt - rd0 !== 2) begin n_bad++; $display("FAIL un_rd_req: got %0d expected 2", rd_cnt - rd0); end
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2;
    logic [7:0] d;
    int drop0;
    drop0 = busy_drop;
    send_start();
    busy_watch = 1'b1;
    wr_byte(8'hA0, a0);
    wr_byte(8'h11, a1);
    bus.tx_valid = 1'b1; bus.tx_data = 8'h5A;
    send_start();
    n_cmp++; if (bus.rx_data !== 8'h11) begin n_bad++; $display("FAIL b2b_rx_data: got %h expected 11", bus.rx_data); end
    wr_byte(8'hA1, a2);
    rd_byte(1'b0, 1'b0, 8'h00, d);
    busy_watch = 1'b0;
    send_stop(); #(2*Q);
    n_cmp++; if ({a0, a1, a2} !== 3'b000) begin n_bad++; $display("FAIL b2b_acks: got %b expected 000", {a0, a1, a2}); end
    n_cmp++; if (d !== 8'h5A) begin n_bad++; $display("FAIL b2b_read: got %h expected 5a", d); end
    n_cmp++; if (busy_drop - drop0 !== 0) begin n_bad++; $display("FAIL b2b_busy: got %0d low cycles expected 0", busy_drop - drop0); end
  endtask

  task automatic test_reset_mid();
    logic a0, s;
    int rx0;
    send_start();
    wr_byte(8'hA0, a0);
    for (int i = 7; i >= 0; i--) bit_x(i[0], s);
    m_sda_low = 1'b0; #Q;
    m_scl = 1'b1; #(Q/2);
    n_cmp++; if (sda !== 1'b0) begin n_bad++; $display("FAIL mid_ack_drive: got %b expected 0", sda); end
    reset = 1'b0;
    #2ns;
    n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL mid_sda_release: got %b expected 1", sda); end
    n_cmp++; if ({bus.rx_data, bus.rx_valid, bus.rd_req, bus.tx_underrun, bus.addr_hit, bus.busy} !== 13'h0)
      begin n_bad++; $display("FAIL mid_outputs: got %h/%b%b%b%b%b expected 00/00000", bus.rx_data,
        bus.rx_valid, bus.rd_req, bus.tx_underrun, bus.addr_hit, bus.busy); end
    #20ns reset = 1'b1;
    #(Q/2); m_scl = 1'b0; #Q;
    send_stop(); #(2*Q);
    rx0 = rx_cnt;
    send_start();
    wr_byte(8'hA0, a0);
    wr_byte(8'hC3, s);
    send_stop(); #(2*Q);
    n_cmp++; if ({a0, s} !== 2'b00) begin n_bad++; $display("FAIL mid_post_acks: got %b expected 00", {a0, s}); end
    n_cmp++; if (rx_cnt - rx0 !== 1 || bus.rx_data !== 8'hC3) begin n_bad++;
      $display("FAIL mid_post_write: got %0d/%h expected 1/c3", rx_cnt - rx0, bus.rx_data); end
  endtask

  // Model: a write is ACKed and delivered iff the address matches; a read returns
  // the offered byte when tx_valid, otherwise FF with an underrun.
  task automatic test_random();
    logic is_read, match, ack;
    logic [6:0] addr;
    logic [7:0] d, got;
    logic [7:0] exp_q[$];
    logic       v[3];
    logic [7:0] td[3];
    int n, rx0, rd0, un0, exp_un;
    for (int t = 0; t < 8; t++) begin
      is_read = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      exp_q.delete();
      if (!is_read) begin
        match = ($urandom_range(0, 3) != 0);
        addr = match ? 7'h50 : 7'($urandom_range(0, 127));
        if (addr == 7'h50) match = 1'b1;
        rx0 = rx_cnt; rx_q.delete();
        send_start();
        wr_byte({addr, 1'b0}, ack);
        n_cmp++; if (ack !== !match) begin n_bad++; $display("FAIL rnd_wr_addr_ack: got %b expected %b", ack, !match); end
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom);
          if (match) exp_q.push_back(d);
          wr_byte(d, ack);
          n_cmp++; if (ack !== !match) begin n_bad++; $display("FAIL rnd_wr_data_ack: got %b expected %b", ack, !match); end
        end
        send_stop(); #(2*Q);
        n_cmp++; if (rx_cnt - rx0 !== exp_q.size()) begin n_bad++;
          $display("FAIL rnd_wr_count: got %0d expected %0d", rx_cnt - rx0, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
          n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd_wr_byte: got %h expected %h", rx_q[i], exp_q[i]); end
        end
      end else begin
        exp_un = 0;
        for (int i = 0; i < 3; i++) begin
          v[i] = 1'($urandom_range(0, 1));
          td[i] = 8'($urandom);
          if (i < n) begin
            exp_q.push_back(v[i] ? td[i] : 8'hFF);
            if (!v[i]) exp_un++;
          end
        end
        rd0 = rd_cnt; un0 = un_cnt;
        bus.tx_valid = v[0]; bus.tx_data = td[0];
        send_start();
        wr_byte(8'hA1, ack);
        n_cmp++; if (ack !== 1'b0) begin n_bad++; $display("FAIL rnd_rd_addr_ack: got %b expected 0", ack); end
        for (int i = 0; i < n; i++) begin
          rd_byte(i < n - 1, (i < 2) ? v[i+1] : 1'b0, (i < 2) ? td[i+1] : 8'h00, got);
          n_cmp++; if (got !== exp_q[i]) begin n_bad++; $display("FAIL rnd_rd_byte: got %h expected %h", got, exp_q[i]); end
        end
        send_stop(); #(2*Q);
        n_cmp++; if (rd_cnt - rd0 !== n) begin n_bad++; $display("FAIL rnd_rd_req: got %0d expected %0d", rd_cnt - rd0, n); end
        n_cmp++; if (un_cnt - un0 !== exp_un) begin n_bad++; $display("FAIL rnd_underrun: got %0d expected %0d", un_cnt - un0, exp_un); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_addr_miss();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50, the 7-bit address this slave answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on scl/sda inputs (minimum 2).
REQ-003 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 scl  input  1  I2C clock from bus/master.
REQ-006 sda  inout  1  I2C data; open-drain only (drives 0 or z, never 1).
REQ-007 rx_data  output  8  last byte written by master, MSB first.
REQ-008 rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-009 tx_data  input  8  byte to return on a master read.
REQ-010 tx_valid  input  1  tx_data holds a fresh byte.
REQ-011 rd_req  output  1  one-cycle pulse, tx_data/tx_valid sampled this cycle.
REQ-012 tx_underrun  output  1  one-cycle pulse, read byte sent without tx_valid.
REQ-013 addr_hit  output  1  high from matched address ACK until STOP/START.
REQ-014 busy  output  1  high from START detect until STOP detect.

Function
REQ-015 scl/sda SHALL pass SYNC_STAGES flops plus one history flop; edges use synchronized values only; clk >= 8x SCL frequency.
REQ-016 START = synced sda 1->0 while synced scl high; STOP = sda 0->1 while scl high; scl_rise/scl_fall = synced scl edges.
REQ-017 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-018 START in any state -> ADDR, bit counter cleared, sda released (repeated START supported).
REQ-019 STOP in any state -> IDLE, sda released, busy and addr_hit cleared; START and STOP never both in one cycle.
REQ-020 ADDR: shift sda on 8 scl_rise; after 8th, upper 7 == SLAVE_ADDR -> ADDR_ACK, else WAIT_STOP (no drive).
REQ-021 ADDR_ACK: drive sda 0 from next scl_fall to following scl_fall; set addr_hit; R/W bit 0 -> WR_DATA, 1 -> RD_DATA.
REQ-022 On entry to RD_DATA (ACK-ending scl_fall) rd_req SHALL pulse; tx_valid=1 loads tx_data, else loads 8'hFF and pulses tx_underrun.
REQ-023 RD_DATA: drive bit MSB first, 0 -> drive low, 1 -> release; change only on scl_fall; after 8th bit's scl_fall release sda -> RD_ACK.
REQ-024 RD_ACK: sample sda on scl_rise; 0 (ACK) -> RD_DATA with REQ-022 reload at next scl_fall; 1 (NACK) -> WAIT_STOP.
REQ-025 WR_DATA: shift sda on 8 scl_rise; on 8th, rx_data updated and rx_valid pulses same cycle -> WR_ACK.
REQ-026 WR_ACK: drive sda 0 for one SCL period as REQ-021, then WR_DATA; no backpressure, unread rx_data overwritten.
REQ-027 WAIT_STOP: sda released, ignore scl until START or STOP.
REQ-028 Bit counter 4 bits, cleared on START and on every ACK-slot exit; never wraps past 8.

Reset
REQ-029 reset low SHALL asynchronously force state IDLE, sda released (z), rx_data 8'h00, rx_valid 0, rd_req 0, tx_underrun 0, addr_hit 0, busy 0, shift regs 0.
REQ-030 Synchronizer flops SHALL reset to 1 (idle bus) so release emits no false START/STOP.
REQ-031 Reset mid-transfer SHALL release sda within the reset cycle; slave resumes at next START.

Structure
REQ-032 State encoding (3-bit), STATE_* constants and I2C_ADDR_W=7 SHALL be in shared package i2c_pkg with master order codes.
REQ-033 One sub-module SHALL be used: i2c_sync_edge (synchronizer + history, outputs synced level, rise, fall), one instance per line.

Verification
REQ-034 START, 0xA0 (addr 0x50 W), byte 0x3C, STOP -> two ACK lows, rx_valid once, rx_data 8'h3C, busy back to 0.
REQ-035 START, 0xA1, tx_data 8'h96 tx_valid=1, master NACK -> rd_req once, sda bits 1,0,0,1,0,1,1,0, WAIT_STOP, IDLE after STOP.
REQ-036 START, 0xA2 (addr 0x51) -> no sda drive, addr_hit 0, rx_valid never pulses until STOP.
REQ-037 Read tx_valid=0, master ACK then NACK -> two 8'hFF bytes, two tx_underrun pulses, two rd_req pulses.
REQ-038 Write 0x11, repeated START, 0xA1 read 0x5A -> rx_data 8'h11, then read 0x5A; busy high throughout.
REQ-039 reset low mid-byte of write -> sda z within one cycle, outputs at REQ-029 values, next full write succeeds.
